fir_sample_sequencer: RTL

Sample sequencer for the 6-tap FIR comparison datapath: accepts one input sample per valid/ready transfer and shifts it into a 6-entry tap window. The window drives the `in_1_0`..`in_6_0` inputs of the accurate and approximate FIR cores in parallel. After a programmable settle interval it captures both cores' `out_11`, forms the signed error, and presents the result on an output valid/ready handshake. Running exact-match and threshold-match counters feed ER0/ER1 characterisation.

---
 rtl/fir_sample_sequencer.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/fir_sample_sequencer.sv
// Sample sequencer for the 6-tap FIR comparison datapath: shifts accepted samples into a
// tap window, waits a settle interval, captures both core outputs and their signed error.
module fir_sample_sequencer #(
    parameter int DATA_W    = 32,
    parameter int SETTLE    = 1,
    parameter int ER_THRESH = 8,
    parameter int CNT_W     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic signed [DATA_W-1:0] s_data,
    output logic signed [DATA_W-1:0] in_1_0,
    output logic signed [DATA_W-1:0] in_2_0,
    output logic signed [DATA_W-1:0] in_3_0,
    output logic signed [DATA_W-1:0] in_4_0,
    output logic signed [DATA_W-1:0] in_5_0,
    output logic signed [DATA_W-1:0] in_6_0,
    input  logic signed [DATA_W-1:0] appr_out,
    input  logic signed [DATA_W-1:0] accu_out,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic signed [DATA_W-1:0] m_appr,
    output logic signed [DATA_W-1:0] m_accu,
    output logic signed [DATA_W:0]   m_err,
    input  logic                     clear,
    output logic [CNT_W-1:0]         n_total,
    output logic [CNT_W-1:0]         n_exact,
    output logic [CNT_W-1:0]         n_thresh
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_HOLD
    } state_e;

    localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);

    state_e                   state_q, state_d;
    logic [3:0]               cnt_q, cnt_d;
    logic signed [DATA_W-1:0] tap_q [6];
    logic signed [DATA_W-1:0] m_appr_q, m_accu_q;
    logic signed [DATA_W:0]   m_err_q;
    logic [CNT_W-1:0]         n_total_q, n_exact_q, n_thresh_q;
    logic                     accept, capture, is_exact, is_thresh;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + 1'b1 : v;
    endfunction

    // Both operands widened by one sign bit, so the difference always fits.
    function automatic logic signed [DATA_W:0] sub_ext(input logic signed [DATA_W-1:0] a,
                                                       input logic signed [DATA_W-1:0] b);
        return {a[DATA_W-1], a} - {b[DATA_W-1], b};
    endfunction

    assign accept    = (state_q == S_IDLE) && s_valid;
    assign capture   = (state_q == S_SETTLE) && (cnt_q == 4'd0);
    assign is_exact  = (appr_out == accu_out);
    assign is_thresh = (appr_out[DATA_W-1:ER_THRESH] == accu_out[DATA_W-1:ER_THRESH]);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (s_valid) begin
                    state_d = S_SETTLE;
                    cnt_d   = SETTLE_M1;
                end
            end
            S_SETTLE: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (m_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Tap window: in_1_0 newest, only moves on an accepted sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 6; i++) tap_q[i] <= '0;
        end else if (accept) begin
            tap_q[0] <= s_data;
            for (int i = 1; i < 6; i++) tap_q[i] <= tap_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_appr_q <= '0;
            m_accu_q <= '0;
            m_err_q  <= '0;
        end else if (capture) begin
            m_appr_q <= appr_out;
            m_accu_q <= accu_out;
            m_err_q  <= sub_ext(appr_out, accu_out);
        end
    end

    // A clear on the capture edge takes priority over the increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_total_q  <= '0;
            n_exact_q  <= '0;
            n_thresh_q <= '0;
        end else if (clear) begin
            n_total_q  <= '0;
            n_exact_q  <= '0;
            n_thresh_q <= '0;
        end else if (capture) begin
            n_total_q  <= sat_inc(n_total_q, 1'b1);
            n_exact_q  <= sat_inc(n_exact_q, is_exact);
            n_thresh_q <= sat_inc(n_thresh_q, is_thresh);
        end
    end

    assign s_ready  = (state_q == S_IDLE);
    assign m_valid  = (state_q == S_HOLD);
    assign in_1_0   = tap_q[0];
    assign in_2_0   = tap_q[1];
    assign in_3_0   = tap_q[2];
    assign in_4_0   = tap_q[3];
    assign in_5_0   = tap_q[4];
    assign in_6_0   = tap_q[5];
    assign m_appr   = m_appr_q;
    assign m_accu   = m_accu_q;
    assign m_err    = m_err_q;
    assign n_total  = n_total_q;
    assign n_exact  = n_exact_q;
    assign n_thresh = n_thresh_q;

endmodule
